// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE bus registers, rising-edge capture of the five
// peripheral lines, priority selection and the request/acknowledge handshake.
module sm83_irq_ctrl #(
   parameter logic [15:0] IF_ADDR = 16'hFF0F,
   parameter logic [15:0] IE_ADDR = 16'hFFFF,
   parameter int unsigned NUM_SRC = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_wr,
   input  logic        bus_rd,
   output logic [7:0]  bus_rdata,
   output logic        bus_sel,
   input  logic [4:0]  irq_src,
   input  logic        ime,
   output logic        int_req,
   output logic [15:0] int_vec,
   input  logic        int_ack,
   output logic        wake
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state_q;
   logic [4:0]  if_q, if_d;
   logic [7:0]  ie_q;
   logic [4:0]  src_q;
   logic [7:0]  rdata_q, rdata_d;
   logic        sel_q;
   logic        req_q;
   logic [15:0] vec_q;

   logic [4:0]  rise, pend, base;
   logic [2:0]  idx, ack_idx;
   logic        found, hit_if, hit_ie, ack_acc;

   assign hit_if  = (bus_addr == IF_ADDR);
   assign hit_ie  = (bus_addr == IE_ADDR);
   assign rise    = irq_src & ~src_q;
   assign pend    = if_q & ie_q[4:0];
   assign wake    = |pend;
   assign ack_acc = (state_q == REQ) && int_ack;
   // The acked source is whatever the presented vector encodes, not the live idx.
   assign ack_idx = vec_q[5:3];

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (pend[i] && !found) begin
            idx   = i[2:0];
            found = 1'b1;
         end
      end
   end

   // Write-clear and ack-clear are applied first so a same-cycle edge always survives.
   always_comb begin
      base = (bus_wr && hit_if) ? bus_wdata[4:0] : if_q;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (ack_acc && (ack_idx == i[2:0])) base[i] = 1'b0;
      end
      if_d = base | rise;
   end

   always_comb begin
      rdata_d = '0;
      if (bus_rd && hit_if)      rdata_d = {3'b111, if_q};
      else if (bus_rd && hit_ie) rdata_d = ie_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_q    <= '0;
         ie_q    <= '0;
         src_q   <= '0;
         rdata_q <= '0;
         sel_q   <= 1'b0;
      end else begin
         src_q   <= irq_src;
         if_q    <= if_d;
         rdata_q <= rdata_d;
         sel_q   <= (bus_rd || bus_wr) && (hit_if || hit_ie);
         if (bus_wr && hit_ie) ie_q <= bus_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         vec_q   <= 16'h0040;
      end else begin
         if (|pend) vec_q <= 16'h0040 + {10'b0, idx, 3'b000};
         case (state_q)
            IDLE: begin
               if (ime && |pend) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state_q <= HOLD;
                  req_q   <= 1'b0;
               end else if (!ime || !(|pend)) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
               end
            end
            HOLD: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus_rdata = rdata_q;
   assign bus_sel   = sel_q;
   assign int_req   = req_q;
   assign int_vec   = vec_q;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed bench for sm83_irq_ctrl: inputs change 1ns after a rising edge,
// outputs are checked after the following edge.
module tb_sm83_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_wr, bus_rd;
   logic [7:0]  bus_rdata;
   logic        bus_sel;
   logic [4:0]  irq_src;
   logic        ime;
   logic        int_req;
   logic [15:0] int_vec;
   logic        int_ack;
   logic        wake;

   int checks   = 0;
   int failures = 0;

   sm83_irq_ctrl #(.IF_ADDR(16'hFF0F), .IE_ADDR(16'hFFFF), .NUM_SRC(5)) dut (
      .clk(clk), .rst(rst),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
      .bus_rdata(bus_rdata), .bus_sel(bus_sel),
      .irq_src(irq_src), .ime(ime),
      .int_req(int_req), .int_vec(int_vec), .int_ack(int_ack), .wake(wake)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [15:0] a);
      bus_addr = a;
      bus_rd   = 1'b1;
      tick();
      bus_rd   = 1'b0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_wr    = 1'b1;
      tick();
      bus_wr    = 1'b0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wr = 1'b0; bus_rd = 1'b0;
      irq_src = '0; ime = 1'b0; int_ack = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_req",  {15'b0, int_req}, 16'h0000);
      chk("rst_wake", {15'b0, wake},    16'h0000);
      chk("rst_vec",  int_vec,          16'h0040);
      chk("rst_sel",  {15'b0, bus_sel}, 16'h0000);
      bus_read(16'hFF0F);
      chk("rst_if",     {8'h00, bus_rdata}, 16'h00E0);
      chk("rst_if_sel", {15'b0, bus_sel},   16'h0001);
      bus_read(16'hFFFF);
      chk("rst_ie", {8'h00, bus_rdata}, 16'h0000);
      bus_read(16'h1234);
      chk("miss_data", {8'h00, bus_rdata}, 16'h0000);
      chk("miss_sel",  {15'b0, bus_sel},   16'h0000);

      // Single timer request and ack
      bus_write(16'hFFFF, 8'h04);
      ime = 1'b1;
      irq_src = 5'b00100; tick(); irq_src = '0;
      tick();
      chk("tmr_req", {15'b0, int_req}, 16'h0001);
      chk("tmr_vec", int_vec,          16'h0050);
      bus_read(16'hFF0F);
      chk("tmr_if", {8'h00, bus_rdata}, 16'h00E4);
      ack();
      chk("tmr_hold_req", {15'b0, int_req}, 16'h0000);
      chk("tmr_wake",     {15'b0, wake},    16'h0000);
      bus_read(16'hFF0F);
      chk("tmr_if_clr", {8'h00, bus_rdata}, 16'h00E0);
      chk("tmr_idle",   {15'b0, int_req},   16'h0000);

      // Higher priority arrival retargets the vector
      bus_write(16'hFFFF, 8'h1F);
      irq_src = 5'b00100; tick();
      irq_src = 5'b00101; tick();
      chk("pri_req",  {15'b0, int_req}, 16'h0001);
      chk("pri_vec0", int_vec,          16'h0050);
      tick();
      chk("pri_vec1", int_vec, 16'h0040);
      ack();
      chk("pri_hold", {15'b0, int_req}, 16'h0000);
      tick();
      chk("pri_idle", {15'b0, int_req}, 16'h0000);
      tick();
      chk("pri_rereq", {15'b0, int_req}, 16'h0001);
      chk("pri_revec", int_vec,          16'h0050);
      bus_read(16'hFF0F);
      chk("pri_if", {8'h00, bus_rdata}, 16'h00E4);
      ack();
      irq_src = '0;
      tick();
      bus_read(16'hFF0F);
      chk("pri_if_clr", {8'h00, bus_rdata}, 16'h00E0);

      // Wake without ime; ack outside REQ is ignored
      ime = 1'b0;
      bus_write(16'hFFFF, 8'h01);
      irq_src = 5'b00001; tick(); irq_src = '0;
      chk("wk_wake", {15'b0, wake},    16'h0001);
      chk("wk_req",  {15'b0, int_req}, 16'h0000);
      ack();
      chk("wk_req2", {15'b0, int_req}, 16'h0000);
      bus_read(16'hFF0F);
      chk("wk_idle_ack", {8'h00, bus_rdata}, 16'h00E1);
      ime = 1'b1;
      tick();
      chk("wk_ime_req", {15'b0, int_req}, 16'h0001);
      chk("wk_ime_vec", int_vec,          16'h0040);
      ack();
      tick();

      // Edge beats a same-cycle write-clear
      ime = 1'b0;
      bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_wr = 1'b1; irq_src = 5'b00010;
      tick();
      bus_wr = 1'b0;
      bus_read(16'hFF0F);
      chk("wc_edge", {8'h00, bus_rdata}, 16'h00E2);
      bus_write(16'hFF0F, 8'h00);
      irq_src = '0;
      bus_read(16'hFF0F);
      chk("wc_clear", {8'h00, bus_rdata}, 16'h00E0);

      // Held line sets the flag once only
      bus_write(16'hFFFF, 8'h08);
      ime = 1'b1;
      irq_src = 5'b01000; tick();
      tick();
      chk("hold_req", {15'b0, int_req}, 16'h0001);
      chk("hold_vec", int_vec,          16'h0058);
      ack();
      for (int i = 0; i < 8; i++) tick();
      chk("hold_noreq",  {15'b0, int_req}, 16'h0000);
      chk("hold_nowake", {15'b0, wake},    16'h0000);
      bus_read(16'hFF0F);
      chk("hold_if", {8'h00, bus_rdata}, 16'h00E0);

      // Reset while requesting
      irq_src = '0; tick();
      irq_src = 5'b01000; tick(); tick();
      chk("mid_req", {15'b0, int_req}, 16'h0001);
      rst = 1'b1; tick(); rst = 1'b0; irq_src = '0;
      chk("mid_rst_req",  {15'b0, int_req}, 16'h0000);
      chk("mid_rst_wake", {15'b0, wake},    16'h0000);
      chk("mid_rst_vec",  int_vec,          16'h0040);

      // Same-cycle read and write of IE returns the old value
      bus_addr = 16'hFFFF; bus_wdata = 8'hA5; bus_wr = 1'b1; bus_rd = 1'b1;
      tick();
      bus_wr = 1'b0; bus_rd = 1'b0;
      chk("rw_old", {8'h00, bus_rdata}, 16'h0000);
      bus_read(16'hFFFF);
      chk("rw_new", {8'h00, bus_rdata}, 16'h00A5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
